path_tracer: RTL and testbench

- Parametrised waypoint animator that moves a point (var_x, var_y) one unit per step tick along a programmable list of NUM_WP waypoints.
- Supports one-shot, loop and ping-pong modes, plus pause.
- Runs only while a key switch pattern is present and the top-level state code lies in a window. Otherwise it parks at the start position.
- Feeds a sprite position to the OLED drawing logic. It replaces fixed-route movers that use hard-coded legs.

---
 rtl/path_tracer.sv | 185 ++++++++++++++++++
 tb/tb_path_tracer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_tracer.sv
// path_tracer: moves a sprite point (var_x, var_y) one unit per qualified step
// along a programmable list of waypoints. Supports one-shot, loop and
// ping-pong routes, and pause. It runs only while armed by a key-switch match
// and a state-code window. Otherwise it parks at (START_X, START_Y).
//
// Ports:
//   variable_clock  movement clock, all logic on rising edge
//   reset_n         synchronous active-low reset
//   SW              switch bank, compared against KEY
//   state           top-level state code, arming window [STATE_LO, STATE_HI)
//   step            move qualifier, one action per clock with step=1
//   pause           freezes position and FSM while high
//   mode            00/11 one-shot, 01 loop, 10 ping-pong
//   wp_x, wp_y      packed waypoints, waypoint i at [i*COORD_W +: COORD_W]
//   var_x, var_y    current position
//   seg_idx         index of current target waypoint
//   dir             0 forward, 1 reverse (ping-pong)
//   done            one-shot route complete
//   moving          high in RUN while not paused
module path_tracer #(
    parameter int unsigned COORD_W  = 7,
    parameter int unsigned NUM_WP   = 6,
    parameter logic [15:0] KEY      = 16'h4345,
    parameter int unsigned STATE_LO = 2,
    parameter int unsigned STATE_HI = 18,
    parameter int unsigned START_X  = 84,
    parameter int unsigned START_Y  = 0
) (
    input  logic                          variable_clock,
    input  logic                          reset_n,
    input  logic [15:0]                   SW,
    input  logic [4:0]                    state,
    input  logic                          step,
    input  logic                          pause,
    input  logic [1:0]                    mode,
    input  logic [NUM_WP*COORD_W-1:0]     wp_x,
    input  logic [NUM_WP*COORD_W-1:0]     wp_y,
    output logic [COORD_W-1:0]            var_x,
    output logic [COORD_W-1:0]            var_y,
    output logic [$clog2(NUM_WP)-1:0]     seg_idx,
    output logic                          dir,
    output logic                          done,
    output logic                          moving
);

    localparam int unsigned SEG_W = $clog2(NUM_WP);
    localparam logic [SEG_W-1:0]   SEG_LAST   = SEG_W'(NUM_WP - 1);
    localparam logic [SEG_W-1:0]   SEG_PREV   = SEG_W'(NUM_WP - 2);
    localparam logic [SEG_W-1:0]   SEG_ONE    = SEG_W'(1);
    localparam logic [COORD_W-1:0] PARK_X     = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] PARK_Y     = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
    localparam logic [1:0]         MODE_LOOP  = 2'b01;
    localparam logic [1:0]         MODE_PINGP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SNAP = 2'd2,
        ST_HOLD = 2'd3
    } tracer_state_t;

    tracer_state_t        state_q;
    tracer_state_t        state_d;
    logic [COORD_W-1:0]   x_d;
    logic [COORD_W-1:0]   y_d;
    logic [SEG_W-1:0]     seg_d;
    logic                 dir_d;
    logic                 done_d;
    logic                 moving_d;

    logic                 arm;
    logic                 qualified;
    logic [COORD_W-1:0]   tx;
    logic [COORD_W-1:0]   ty;
    logic [COORD_W-1:0]   wp_x_arr [NUM_WP];
    logic [COORD_W-1:0]   wp_y_arr [NUM_WP];

    // Unpack the waypoint buses so the target can be read live by seg_idx.
    for (genvar i = 0; i < NUM_WP; i++) begin : g_wp
        assign wp_x_arr[i] = wp_x[i*COORD_W +: COORD_W];
        assign wp_y_arr[i] = wp_y[i*COORD_W +: COORD_W];
    end

    assign tx = wp_x_arr[seg_idx];
    assign ty = wp_y_arr[seg_idx];

    // Arming: state is unsigned and compared in 32 bits so any window bounds fit.
    assign arm = (32'(state) >= STATE_LO) && (32'(state) < STATE_HI) && (SW == KEY);

    assign qualified = step && !pause;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        x_d      = var_x;
        y_d      = var_y;
        seg_d    = seg_idx;
        dir_d    = dir;
        done_d   = done;
        moving_d = 1'b0;

        if (!arm) begin
            state_d = ST_IDLE;
            x_d     = PARK_X;
            y_d     = PARK_Y;
            seg_d   = '0;
            dir_d   = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (qualified) begin
                        // x is corrected before y, one unit per tick.
                        if (var_x != tx) begin
                            x_d = (tx > var_x) ? var_x + COORD_ONE : var_x - COORD_ONE;
                        end else if (var_y != ty) begin
                            y_d = (ty > var_y) ? var_y + COORD_ONE : var_y - COORD_ONE;
                        end else if (!dir && (seg_idx == SEG_LAST)) begin
                            // Route end: mode is only looked at here.
                            if (mode == MODE_LOOP) begin
                                state_d = ST_SNAP;
                            end else if (mode == MODE_PINGP) begin
                                dir_d = 1'b1;
                                seg_d = SEG_PREV;
                            end else begin
                                state_d = ST_HOLD;
                                done_d  = 1'b1;
                            end
                        end else if (dir && (seg_idx == '0)) begin
                            dir_d = 1'b0;
                            seg_d = SEG_ONE;
                        end else if (dir) begin
                            seg_d = seg_idx - SEG_ONE;
                        end else begin
                            seg_d = seg_idx + SEG_ONE;
                        end
                    end
                end
                ST_SNAP: begin
                    if (qualified) begin
                        x_d     = PARK_X;
                        y_d     = PARK_Y;
                        seg_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            moving_d = (state_d == ST_RUN) && !pause;
        end
    end

    // State and output registers; reset parks exactly like a disarm.
    always_ff @(posedge variable_clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            var_x   <= PARK_X;
            var_y   <= PARK_Y;
            seg_idx <= '0;
            dir     <= 1'b0;
            done    <= 1'b0;
            moving  <= 1'b0;
        end else begin
            state_q <= state_d;
            var_x   <= x_d;
            var_y   <= y_d;
            seg_idx <= seg_d;
            dir     <= dir_d;
            done    <= done_d;
            moving  <= moving_d;
        end
    end

endmodule

// File: tb/tb_path_tracer.sv
// Testbench for path_tracer: directed route scenarios followed by randomized
// stimulus, every edge compared against a behavioural route model.
module tb_path_tracer;

    localparam int unsigned CW    = 7;
    localparam int unsigned NW    = 6;
    localparam int unsigned SEG_W = 3;
    localparam logic [15:0] KEY   = 16'h4345;
    localparam int          SX    = 84;
    localparam int          SY    = 0;

    logic               variable_clock = 1'b0;
    logic               reset_n;
    logic [15:0]        SW;
    logic [4:0]         state;
    logic               step;
    logic               pause;
    logic [1:0]         mode;
    logic [NW*CW-1:0]   wp_x;
    logic [NW*CW-1:0]   wp_y;
    logic [CW-1:0]      var_x;
    logic [CW-1:0]      var_y;
    logic [SEG_W-1:0]   seg_idx;
    logic               dir;
    logic               done;
    logic               moving;

    int wx[NW];
    int wy[NW];

    int checks   = 0;
    int failures = 0;

    // Model: where the sprite is on its route and what the route is doing.
    typedef enum int {P_PARKED, P_TRAVEL, P_RETURN, P_FINISHED} phase_t;
    phase_t ph;
    int     mx, my, mseg;
    bit     mdir, mdone, mmov;

    always #5 variable_clock = ~variable_clock;

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            wp_x[i*CW +: CW] = CW'(wx[i]);
            wp_y[i*CW +: CW] = CW'(wy[i]);
        end
    end

    path_tracer dut (
        .variable_clock (variable_clock),
        .reset_n        (reset_n),
        .SW             (SW),
        .state          (state),
        .step           (step),
        .pause          (pause),
        .mode           (mode),
        .wp_x           (wp_x),
        .wp_y           (wp_y),
        .var_x          (var_x),
        .var_y          (var_y),
        .seg_idx        (seg_idx),
        .dir            (dir),
        .done           (done),
        .moving         (moving)
    );

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic park();
        ph = P_PARKED; mx = SX; my = SY; mseg = 0;
        mdir = 1'b0; mdone = 1'b0; mmov = 1'b0;
    endtask

    // One qualified action of a travelling route.
    task automatic travel();
        int tx = wx[mseg];
        int ty = wy[mseg];
        if (mx != tx)      mx += (tx > mx) ? 1 : -1;
        else if (my != ty) my += (ty > my) ? 1 : -1;
        else if (!mdir && mseg == NW - 1) begin
            if (mode == 2'd1) ph = P_RETURN;
            else if (mode == 2'd2) begin mdir = 1'b1; mseg = NW - 2; end
            else begin ph = P_FINISHED; mdone = 1'b1; end
        end else if (mdir && mseg == 0) begin
            mdir = 1'b0; mseg = 1;
        end else begin
            mseg += mdir ? -1 : 1;
        end
    endtask

    // Model update for one clock edge using the inputs applied before it.
    task automatic model_edge();
        int  st    = int'(state);
        bit  armed = (st >= 2) && (st < 18) && (SW == KEY);
        if (!reset_n || !armed) begin
            park();
            return;
        end
        if (!pause) begin
            case (ph)
                P_PARKED: ph = P_TRAVEL;
                P_TRAVEL: if (step) travel();
                P_RETURN: if (step) begin mx = SX; my = SY; mseg = 0; ph = P_TRAVEL; end
                default: ;
            endcase
        end
        mmov = (ph == P_TRAVEL) && !pause;
    endtask

    task automatic tick(input bit st, input bit ps);
        step  = st;
        pause = ps;
        @(posedge variable_clock);
        model_edge();
        #1;
        check("var_x",   32'(var_x),   mx);
        check("var_y",   32'(var_y),   my);
        check("seg_idx", 32'(seg_idx), mseg);
        check("dir",     32'(dir),     int'(mdir));
        check("done",    32'(done),    int'(mdone));
        check("moving",  32'(moving),  int'(mmov));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1'b1, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic route_a();
        wx[0] = 84; wy[0] = 3;
        for (int i = 1; i < NW; i++) begin wx[i] = 80; wy[i] = 3; end
    endtask

    task automatic route_b();
        wx[0] = 84; wy[0] = 2;
        wx[1] = 82; wy[1] = 2;
        for (int i = 2; i < NW; i++) begin wx[i] = 82; wy[i] = 0; end
    endtask

    initial begin
        park();
        reset_n = 1'b0; SW = KEY; state = 5'd5; mode = 2'd0;
        step = 1'b0; pause = 1'b0;
        route_a();

        // Reset state.
        tick(1'b1, 1'b0);
        check("rst_x", 32'(var_x), 84);
        check("rst_y", 32'(var_y), 0);
        check("rst_seg", 32'(seg_idx), 0);
        check("rst_done", 32'(done), 0);
        check("rst_moving", 32'(moving), 0);
        reset_n = 1'b1;

        // One-shot route.
        tick_n(1);
        check("os_moving", 32'(moving), 1);
        tick_n(3);
        check("os_y3", 32'(var_y), 3);
        tick_n(1);
        check("os_seg1", 32'(seg_idx), 1);
        tick_n(4);
        check("os_x80", 32'(var_x), 80);
        tick_n(4);
        check("os_notdone", 32'(done), 0);
        tick_n(1);
        check("os_done", 32'(done), 1);
        tick_n(20);
        check("os_hold_x", 32'(var_x), 80);
        check("os_hold_y", 32'(var_y), 3);
        check("os_hold_done", 32'(done), 1);

        // Loop route.
        mode = 2'd1;
        do_reset();
        tick_n(14);
        check("lp_snap_done", 32'(done), 0);
        tick_n(1);
        check("lp_x", 32'(var_x), 84);
        check("lp_y", 32'(var_y), 0);
        check("lp_seg", 32'(seg_idx), 0);
        tick_n(3);
        check("lp_y3", 32'(var_y), 3);

        // Ping-pong route.
        mode = 2'd2;
        route_b();
        do_reset();
        tick_n(13);
        check("pp_dir1", 32'(dir), 1);
        check("pp_seg4", 32'(seg_idx), 4);
        tick_n(3);
        check("pp_seg1", 32'(seg_idx), 1);
        tick_n(2);
        check("pp_ret_x", 32'(var_x), 82);
        check("pp_ret_y", 32'(var_y), 2);
        tick_n(4);
        check("pp_dir0", 32'(dir), 0);
        check("pp_seg_again", 32'(seg_idx), 1);

        // Arming window and key.
        mode = 2'd0;
        route_a();
        do_reset();
        state = 5'd1;
        tick_n(5);
        check("arm_lo_y", 32'(var_y), 0);
        state = 5'd18;
        tick_n(5);
        check("arm_hi_moving", 32'(moving), 0);
        state = 5'd17;
        tick_n(2);
        check("arm_17_y", 32'(var_y), 1);
        tick_n(5);
        SW = KEY ^ 16'h0001;
        tick_n(1);
        check("disarm_x", 32'(var_x), 84);
        check("disarm_seg", 32'(seg_idx), 0);
        SW = KEY; state = 5'd5;

        // Step/pause gating and reset under pause.
        tick_n(1);
        for (int i = 0; i < 16; i++) tick(i % 4 == 0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        reset_n = 1'b0;
        tick(1'b1, 1'b1);
        check("rstp_x", 32'(var_x), 84);
        check("rstp_moving", 32'(moving), 0);
        reset_n = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);

        // Live waypoint edit while heading to wp1.
        do_reset();
        tick_n(1 + 3 + 1 + 2);
        check("edit_x82", 32'(var_x), 82);
        for (int i = 1; i < NW; i++) wx[i] = 88;
        tick_n(1);
        check("edit_x83", 32'(var_x), 83);
        tick_n(5);
        check("edit_x88", 32'(var_x), 88);
        check("edit_notdone", 32'(done), 0);
        tick_n(5);
        check("edit_done", 32'(done), 1);

        // Randomized operation.
        for (int i = 0; i < NW; i++) begin
            wx[i] = 78 + int'($urandom_range(12));
            wy[i] = int'($urandom_range(6));
        end
        for (int c = 0; c < 2500; c++) begin
            reset_n = ($urandom_range(199) != 0);
            state   = ($urandom_range(49) == 0) ? 5'($urandom_range(31)) : 5'd5;
            SW      = ($urandom_range(99) == 0) ? KEY ^ 16'($urandom_range(1, 65535)) : KEY;
            if ($urandom_range(99) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(29) == 0) begin
                int k = int'($urandom_range(NW - 1));
                wx[k] = 78 + int'($urandom_range(12));
                wy[k] = int'($urandom_range(6));
            end
            tick($urandom_range(2) != 0, $urandom_range(9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
